// File: rtl/stack_ram.sv
// Pop-side RAM for a hardware stack: single-write/single-read synchronous RAM with an IDLE/READ/HOLD pop handshake.
// Define STACK_RAM_UFLOW_EN to flag pops at the empty marker (address 0) as errors and return zero for them.
module stack_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] stackAddr,
  input  logic              stackoverflow,
  input  logic              ready,
  output logic              readIt,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              read_it;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              push_req, pop_acc, wr_en;

`ifdef STACK_RAM_UFLOW_EN
  logic uflow_q, uflow_d;
`endif

  assign push_req = s & push;
  assign pop_acc  = s & pop & ~push & (state_q == IDLE);
  assign wr_en    = push_req & ~stackoverflow & (stackAddr != '0);

  // Outside IDLE the read port stays parked on the latched pop address.
  assign rd_addr  = (state_q == IDLE) ? stackAddr : addr_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[stackAddr] <= din;
    rd_data_q <= mem[rd_addr];
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    err_d   = err_q;
    read_it = 1'b0;
`ifdef STACK_RAM_UFLOW_EN
    uflow_d = uflow_q;
`endif
    if (push_req && stackoverflow) err_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (pop_acc) begin
          addr_d  = stackAddr;
          state_d = READ;
`ifdef STACK_RAM_UFLOW_EN
          uflow_d = (stackAddr == '0);
          if (stackAddr == '0) err_d = 1'b1;
`endif
        end
      end
      READ: begin
        // A push here means the pointer unit has cancelled this pop.
        if (push_req) begin
          state_d = IDLE;
        end else begin
`ifdef STACK_RAM_UFLOW_EN
          dout_d  = uflow_q ? '0 : rd_data_q;
`else
          dout_d  = rd_data_q;
`endif
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (push_req) begin
          state_d = IDLE;
        end else if (ready) begin
          read_it = rst;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
`ifdef STACK_RAM_UFLOW_EN
      uflow_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
`ifdef STACK_RAM_UFLOW_EN
      uflow_q <= uflow_d;
`endif
    end
  end

  assign readIt = read_it;
  assign dout   = dout_q;
  assign dvalid = (state_q == HOLD);
  assign busy   = (state_q != IDLE);
  assign err    = err_q;

endmodule

// File: tb/tb_stack_ram.sv
// Scoreboarded bench for stack_ram: directed scenarios followed by random push/pop traffic against a stack memory model.
module tb_stack_ram;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, s, push, pop, stackoverflow, ready;
  logic [DW-1:0] din;
  logic [AW-1:0] stackAddr;
  logic          readIt, dvalid, busy, err;
  logic [DW-1:0] dout;

  stack_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .s(s), .push(push), .pop(pop), .din(din),
    .stackAddr(stackAddr), .stackoverflow(stackoverflow), .ready(ready),
    .readIt(readIt), .dout(dout), .dvalid(dvalid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] data;
    bit            known;
  } exp_t;
  exp_t sb_q[$];

  // Reference: stack memory contents, one outstanding pop with its age in cycles.
  logic [DW-1:0] m_mem [256];
  bit            m_wr  [256];
  bit            m_pend = 0;
  int            m_age = 0;
  bit            m_err = 0;
  bit            e_readIt, e_dvalid, e_busy, e_err;
  bit            chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("readIt", readIt, e_readIt);
      check("dvalid", dvalid, e_dvalid);
      check("busy", busy, e_busy);
      check("err", err, e_err);
      if (dvalid === 1'b1) begin
        check("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          if (sb_q[0].known) check("dout", dout, sb_q[0].data);
          if (readIt === 1'b1) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit r, input bit ss, input bit pu, input bit po, input bit ov,
                      input bit rd, input logic [DW-1:0] d, input logic [AW-1:0] a);
    exp_t e;
    rst = r; s = ss; push = pu; pop = po; stackoverflow = ov; ready = rd; din = d; stackAddr = a;
    e_readIt = r && m_pend && m_age >= 2 && rd && !(ss && pu);
    e_dvalid = m_pend && m_age >= 2;
    e_busy   = m_pend;
    e_err    = m_err;
    chk_en   = 1;
    @(posedge clk);
    if (ss && pu && !ov && a != 0) begin
      m_mem[a] = d;
      m_wr[a]  = 1;
    end
    if (!r) begin
      m_pend = 0;
      m_err  = 0;
      sb_q.delete();
    end else if (ss && pu) begin
      if (ov) m_err = 1;
      if (m_pend) begin
        m_pend = 0;
        if (sb_q.size() != 0) void'(sb_q.pop_back());
      end
    end else if (ss && po && !m_pend) begin
`ifdef STACK_RAM_UFLOW_EN
      if (a == 0) begin
        e.data = '0; e.known = 1; m_err = 1;
      end else begin
        e.data = m_mem[a]; e.known = m_wr[a];
      end
`else
      e.data = m_mem[a]; e.known = m_wr[a];
`endif
      sb_q.push_back(e);
      m_pend = 1;
      m_age  = 0;
    end else if (e_readIt) begin
      m_pend = 0;
    end
    if (m_pend) m_age++;
    #1;
  endtask

  task automatic idle(input bit rd, input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, rd, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin m_mem[i] = '0; m_wr[i] = 0; end
    rst = 0; s = 0; push = 0; pop = 0; stackoverflow = 0; ready = 0; din = '0; stackAddr = '0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, '0, '0);
    check("dout_after_reset", dout, 0);

    // Basic push then pop with ready high.
    step(1, 1, 1, 0, 0, 1, 16'h1234, 8'd1);
    step(1, 1, 0, 1, 0, 1, '0, 8'd1);
    idle(1, 3);

    // Held output while the consumer stalls.
    step(1, 1, 1, 0, 0, 0, 16'hAAAA, 8'd1);
    step(1, 1, 1, 0, 0, 0, 16'hBBBB, 8'd2);
    step(1, 1, 0, 1, 0, 0, '0, 8'd2);
    idle(0, 6);
    idle(1, 2);

    // Pop cancelled by a push while the read is in flight.
    step(1, 1, 0, 1, 0, 1, '0, 8'd1);
    step(1, 1, 1, 0, 0, 1, 16'h0F0F, 8'd3);
    idle(1, 3);
    step(1, 1, 0, 1, 0, 1, '0, 8'd3);
    idle(1, 3);

    // Overflowed push leaves the top entry intact and latches err.
    step(1, 1, 1, 0, 0, 1, 16'h5555, 8'd255);
    step(1, 1, 1, 0, 1, 1, 16'hDEAD, 8'd255);
    step(1, 1, 0, 1, 0, 1, '0, 8'd255);
    idle(1, 3);
    step(0, 0, 0, 0, 0, 0, '0, '0);
    idle(1, 1);

    // Pop at the empty marker.
    step(1, 1, 0, 1, 0, 1, '0, 8'd0);
    idle(1, 3);
    step(0, 0, 0, 0, 0, 0, '0, '0);

    // Reset while holding data.
    step(1, 1, 1, 0, 0, 0, 16'h7777, 8'd5);
    step(1, 1, 0, 1, 0, 0, '0, 8'd5);
    idle(0, 3);
    step(0, 0, 0, 0, 0, 1, '0, '0);
    idle(1, 2);

    for (int i = 0; i < 3000; i++) begin
      bit r, ss, pu, po, ov, rd;
      logic [AW-1:0] a;
      r  = ($urandom_range(0, 99) != 0);
      ss = r && ($urandom_range(0, 9) < 7);
      pu = ($urandom_range(0, 9) < 3);
      po = ($urandom_range(0, 9) < 4);
      ov = pu && ($urandom_range(0, 19) == 0);
      rd = ($urandom_range(0, 9) < 6);
      if (ov) a = 8'd255;
      else if (!pu && $urandom_range(0, 49) == 0) a = 8'd0;
      else a = 8'($urandom_range(1, 15));
      step(r, ss, pu, po, ov, rd, 16'($urandom), a);
    end
    idle(1, 4);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stack_ram.md
STACK_RAM -- requirements
Module: stack_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the width of a stack entry.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the address width (256 entries).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, reset: synchronous and active-low.
REQ-005 SHALL have port s, input, 1, stack-instruction strobe.
REQ-006 SHALL have port push, input, 1, push request, qualified by s.
REQ-007 SHALL have port pop, input, 1, pop request, qualified by s.
REQ-008 SHALL have port din, input, DATA_W, push data.
REQ-009 SHALL have port stackAddr, input, ADDR_W, current stack address from the pointer unit (combinational, already incremented on push).
REQ-010 SHALL have port stackoverflow, input, 1, pointer over/underflow flag.
REQ-011 SHALL have port ready, input, 1, consumer accepts dout.
REQ-012 SHALL have port readIt, output, 1, pop-consumed pulse back to the pointer unit.
REQ-013 SHALL have port dout, output, DATA_W, popped data.
REQ-014 SHALL have port dvalid, output, 1, dout valid.
REQ-015 SHALL have port busy, output, 1, pop in flight.
REQ-016 SHALL have port err, output, 1, sticky error flag.

Function
REQ-017 SHALL hold 2**ADDR_W x DATA_W synchronous RAM; 1 write port, 1 read port, 1-cycle read latency; address 0 is never written (empty marker).
REQ-018 SHALL write din to RAM[stackAddr] at the clock edge of any cycle with s&push&!stackoverflow, in any FSM state.
REQ-019 SHALL suppress the write and set err when s&push&stackoverflow (full at 255).
REQ-020 SHALL use the FSM states IDLE, READ and HOLD; busy = (state != IDLE).
REQ-021 IDLE: s&pop&!push -> issue RAM read at stackAddr, latch the address, go to READ.
REQ-022 READ: next cycle -> capture RAM data into dout, go to HOLD.
REQ-023 HOLD: dvalid=1; dout held stable until ready.
REQ-024 HOLD&ready: readIt=1 combinationally in the same cycle, next state IDLE, dvalid falls next cycle.
REQ-025 readIt SHALL be high only in a HOLD&ready cycle; it is a single-cycle pulse per pop.
REQ-026 s&push while busy: perform the write (REQ-018), abort the pop (next state IDLE, dvalid=0, no readIt); this matches the pointer unit cancelling its pending pop.
REQ-027 s&pop while busy: ignored; no second read, no error.
REQ-028 s&push&pop together: push wins, pop ignored.
REQ-029 Pop latency: s&pop at cycle N -> dvalid at N+2 at the earliest; readIt at the first HOLD&ready cycle.

Reset
REQ-030 rst low at a clock edge SHALL force state=IDLE, dout=0, dvalid=0, readIt=0, busy=0, err=0.
REQ-031 Reset mid-pop SHALL drop dvalid with no readIt pulse; RAM contents are undefined after reset and are not cleared.
REQ-032 err SHALL clear only on reset.

Configuration
REQ-033 Macro STACK_RAM_UFLOW_EN SHALL enable underflow detection.
REQ-034 With STACK_RAM_UFLOW_EN defined: a pop accepted in IDLE with stackAddr==0 sets err; dout=0; the FSM still runs READ->HOLD and issues readIt on ready, so the pointer clears its pop.
REQ-035 Without STACK_RAM_UFLOW_EN: a pop at address 0 returns RAM[0] unchanged, err is untouched, and timing is identical.

Verification
REQ-036 Reset, then push 0x1234 at stackAddr=1, pop with stackAddr=1 and ready=1 -> dout=0x1234, dvalid at pop+2, readIt one cycle, then IDLE.
REQ-037 Push 0xAAAA@1 and 0xBBBB@2, pop @2 with ready held low 5 cycles -> dvalid and dout=0xBBBB stable for 5 cycles, readIt only on the ready cycle.
REQ-038 Pop in flight (READ), then s&push din=0x0F0F@3 -> RAM[3]=0x0F0F, dvalid never asserts, no readIt.
REQ-039 s&push with stackoverflow=1, stackAddr=255 -> RAM[255] unchanged, err=1 until rst low.
REQ-040 With STACK_RAM_UFLOW_EN, pop at stackAddr=0 -> err=1, dout=0, readIt pulses; without the macro -> err=0, dout=RAM[0].
REQ-041 rst low during HOLD -> next cycle dvalid=0, busy=0, no readIt.
